// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a fixed-latency FIFO read port into a valid/ready stream,
// parking returning words in a skid buffer sized to cover everything still in flight.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              fifo_empty,
    output logic                              fifo_rd,
    input  logic [DATA_WIDTH-1:0]             fifo_dout,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic [$clog2(RD_LATENCY+3)-1:0]   buf_level,
    output logic                              err_ovf
);
    localparam int BUF_DEPTH = RD_LATENCY + 2;
    localparam int LW = $clog2(BUF_DEPTH + 1);
    localparam int PW = $clog2(BUF_DEPTH);

    logic                  rd_req;
    logic [RD_LATENCY-1:0] pipe;
    logic [RD_LATENCY-1:0] pipe_nxt;
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         count;
    logic [LW-1:0]         count_nxt;
    logic [LW:0]           inflight;
    logic [LW:0]           commit;
    logic                  push;
    logic                  pop;
    logic                  accept;
    logic                  ovf;

    // The request is registered; masking with the live empty flag keeps a stale
    // request from popping a FIFO that drained on the previous edge.
    assign fifo_rd   = rd_req && !fifo_empty;
    assign m_valid   = count != '0;
    assign m_data    = m_valid ? mem[rd_ptr] : '0;
    assign buf_level = count;

    assign push      = pipe[RD_LATENCY-1];
    assign pop       = m_valid && m_ready;
    assign accept    = push && (count != LW'(BUF_DEPTH) || pop);
    assign ovf       = push && !accept;
    assign count_nxt = (accept && !pop) ? count + LW'(1) :
                       (!accept && pop) ? count - LW'(1) : count;

    // Words committed after this edge: stored plus every read still travelling.
    always_comb begin
        pipe_nxt    = pipe << 1;
        pipe_nxt[0] = fifo_rd;
        inflight    = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            inflight = inflight + (LW+1)'(pipe_nxt[i]);
        commit      = {1'b0, count_nxt} + inflight;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_req  <= 1'b0;
            pipe    <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_ovf <= 1'b0;
        end else begin
            rd_req  <= !fifo_empty && commit < (LW+1)'(BUF_DEPTH);
            pipe    <= pipe_nxt;
            wr_ptr  <= !accept ? wr_ptr : wr_ptr == PW'(BUF_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
            rd_ptr  <= !pop ? rd_ptr : rd_ptr == PW'(BUF_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
            count   <= count_nxt;
            err_ovf <= err_ovf || ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= fifo_dout;
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: FIFO model feeding two reader instances (latency 1 and 3),
// scoreboard of words popped from the FIFO versus words handed out on the stream.
module tb_fifo_stream_reader;
    localparam int DW = 16;

    typedef struct {
        logic sel;
        int   n;
        int   mode;
        int   exp_first;
        int   exp_last;
        int   max_lvl;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          m_ready;
    logic          sel;
    logic          model_empty;
    logic [DW-1:0] dpipe [3];
    logic          empty0, empty1, rd0, rd1, v0, v1, ovf0, ovf1;
    logic [DW-1:0] d0, d1;
    logic [1:0]    lvl0;
    logic [2:0]    lvl1;
    logic          cv, crd, covf;
    logic [DW-1:0] cd;
    logic [2:0]    cl;

    logic [DW-1:0] fq [$];
    logic [DW-1:0] exp_q [$];
    int            errors = 0;
    int            checks = 0;
    int            cyc, delivered, first_cyc, last_cyc, max_lvl, pops;
    logic [DW-1:0] first_data, prev_data;
    logic          prev_hold, rd_seen;
    vec_t          vecs [4];

    always #5 clk = ~clk;

    assign empty0 = sel ? 1'b1 : model_empty;
    assign empty1 = sel ? model_empty : 1'b1;
    assign cv     = sel ? v1 : v0;
    assign crd    = sel ? rd1 : rd0;
    assign cd     = sel ? d1 : d0;
    assign cl     = sel ? lvl1 : {1'b0, lvl0};
    assign covf   = sel ? ovf1 : ovf0;

    fifo_stream_reader #(.DATA_WIDTH(DW), .RD_LATENCY(1)) dut0 (
        .clk(clk), .rst(rst), .fifo_empty(empty0), .fifo_rd(rd0), .fifo_dout(dpipe[0]),
        .m_valid(v0), .m_ready(m_ready), .m_data(d0), .buf_level(lvl0), .err_ovf(ovf0)
    );
    fifo_stream_reader #(.DATA_WIDTH(DW), .RD_LATENCY(3)) dut1 (
        .clk(clk), .rst(rst), .fifo_empty(empty1), .fifo_rd(rd1), .fifo_dout(dpipe[2]),
        .m_valid(v1), .m_ready(m_ready), .m_data(d1), .buf_level(lvl1), .err_ovf(ovf1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Observe at the falling edge, then advance the FIFO model just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (cv && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected none (cycle %0d)", cd, cyc);
            end else
                check("word_order", cd, exp_q.pop_front());
            if (delivered == 0) begin
                first_cyc  = cyc;
                first_data = cd;
            end
            delivered++;
            last_cyc = cyc;
        end
        if (prev_hold) begin
            check("hold_valid", cv, 1);
            check("hold_data", cd, prev_data);
        end
        prev_hold = cv && !m_ready;
        prev_data = cd;
        if (int'(cl) > max_lvl) max_lvl = int'(cl);
        if (crd) check("rd_while_empty", model_empty, 0);
        rd_seen = crd;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 2; i > 0; i--) dpipe[i] = dpipe[i-1];
        dpipe[0] = 16'hDEAD;
        if (rd_seen && fq.size() > 0) begin
            dpipe[0] = fq.pop_front();
            exp_q.push_back(dpipe[0]);
            pops++;
        end
        model_empty = fq.size() == 0;
    endtask

    task automatic reset_env();
        rst         = 1'b1;
        m_ready     = 1'b0;
        fq.delete();
        model_empty = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) dpipe[i] = '0;
        prev_hold = 1'b0;
        cyc       = 0;
        delivered = 0;
        pops      = 0;
        max_lvl   = 0;
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) fq.push_back(DW'(base + i));
        model_empty = fq.size() == 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // mode 0: always ready, 1: ready on even cycles, 2: stalled until cycle 20
        vecs[0] = '{sel: 1'b0, n: 8,  mode: 0, exp_first: 3,  exp_last: 10, max_lvl: 1};
        vecs[1] = '{sel: 1'b0, n: 8,  mode: 2, exp_first: 20, exp_last: 27, max_lvl: 3};
        vecs[2] = '{sel: 1'b0, n: 16, mode: 1, exp_first: 4,  exp_last: 34, max_lvl: 3};
        vecs[3] = '{sel: 1'b1, n: 32, mode: 0, exp_first: 5,  exp_last: 36, max_lvl: 5};
        for (int i = 0; i < 3; i++) dpipe[i] = '0;
        sel = 1'b0;
        cyc = 0;
        delivered = 0;
        prev_hold = 1'b0;
        reset_env();
        check("rst_rd0", rd0, 0);
        check("rst_valid0", v0, 0);
        check("rst_data0", d0, 0);
        check("rst_level0", lvl0, 0);
        check("rst_ovf0", ovf0, 0);
        check("rst_rd1", rd1, 0);
        check("rst_valid1", v1, 0);
        check("rst_data1", d1, 0);
        check("rst_level1", lvl1, 0);
        check("rst_ovf1", ovf1, 0);

        foreach (vecs[v]) begin
            sel = vecs[v].sel;
            reset_env();
            fill(vecs[v].n, 1);
            while (delivered < vecs[v].n && cyc < 300) begin
                m_ready = vecs[v].mode == 0 ? 1'b1 :
                          vecs[v].mode == 1 ? (cyc % 2 == 0) : (cyc >= 20);
                if (vecs[v].mode == 2 && cyc == 19) begin
                    check("stall_level", cl, 3);
                    check("stall_pops", pops, 3);
                    check("stall_rd", crd, 0);
                    check("stall_data", cd, 1);
                end
                tick();
            end
            m_ready = 1'b1;
            for (int k = 0; k < 6; k++) tick();
            check("delivered", delivered, vecs[v].n);
            check("first_cycle", first_cyc, vecs[v].exp_first);
            check("last_cycle", last_cyc, vecs[v].exp_last);
            check("max_level_ok", max_lvl <= vecs[v].max_lvl, 1);
            check("scoreboard_empty", exp_q.size(), 0);
            check("no_ovf", covf, 0);
        end

        // Reset with 3 words buffered and 2 in flight on the latency-3 reader.
        sel = 1'b1;
        reset_env();
        fill(16, 1);
        while (cl != 3 && cyc < 50) tick();
        check("pre_rst_level", cl, 3);
        check("pre_rst_pops", pops, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        prev_hold = 1'b0;
        check("post_rst_valid", cv, 0);
        check("post_rst_rd", crd, 0);
        check("post_rst_level", cl, 0);
        m_ready   = 1'b1;
        delivered = 0;
        cyc       = 0;
        while (delivered < 11 && cyc < 100) tick();
        for (int k = 0; k < 6; k++) tick();
        check("resume_count", delivered, 11);
        check("resume_head", first_data, 6);
        check("resume_sb_empty", exp_q.size(), 0);
        check("resume_no_ovf", covf, 0);

        // Empty FIFO: nothing may be read or presented.
        sel = 1'b0;
        reset_env();
        m_ready = 1'b1;
        begin
            int bad = 0;
            for (int k = 0; k < 100; k++) begin
                if (cv || crd) bad++;
                tick();
            end
            check("idle_quiet", bad, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
